// File: rtl/seg7_pkg.sv
// Shared segment patterns for the seven-segment scan driver.
// Patterns are active-low {a,b,c,d,e,f,g}, bit 6 = a.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_A     = 7'b0001000;
  localparam logic [6:0] SEG_B     = 7'b1100000;
  localparam logic [6:0] SEG_C     = 7'b0110001;
  localparam logic [6:0] SEG_D     = 7'b1000010;
  localparam logic [6:0] SEG_E     = 7'b0110000;
  localparam logic [6:0] SEG_F     = 7'b0111000;

  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host/panel side bundle of the scan driver: load path in, display drive out.
interface seg7_scan_driver_if #(
  parameter int unsigned N_DIGITS = 4
);
  logic                    load;
  logic [4*N_DIGITS-1:0]   digits_in;
  logic [N_DIGITS-1:0]     dp_in;
  logic                    blank_lz;
  logic                    pending;
  logic                    frame_tick;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [N_DIGITS-1:0]     an_n;

  modport master (
    output load, digits_in, dp_in, blank_lz,
    input  pending, frame_tick, seg_n, dp_n, an_n
  );

  modport slave (
    input  load, digits_in, dp_in, blank_lz,
    output pending, frame_tick, seg_n, dp_n, an_n
  );
endinterface

// File: rtl/hex_to_seg7.sv
// Combinational nibble to active-low segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_n
);
  assign o_seg_n = nibble_to_seg(i_nibble);
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with frame-synchronous buffering,
// one-clock dead-time per slot and optional leading-zero blanking.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int unsigned N_DIGITS = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  seg7_scan_driver_if.slave  bus
);
  localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned DIG_W = 4 * N_DIGITS;

  logic [DIV_W-1:0]    r_div,        w_div_nxt;
  logic [IDX_W-1:0]    r_idx,        w_idx_nxt;
  logic [DIG_W-1:0]    r_shadow_dig, w_shadow_dig_nxt;
  logic [N_DIGITS-1:0] r_shadow_dp,  w_shadow_dp_nxt;
  logic [DIG_W-1:0]    r_active_dig, w_active_dig_nxt;
  logic [N_DIGITS-1:0] r_active_dp,  w_active_dp_nxt;
  logic                r_pending,    w_pending_nxt;
  logic                r_frame_tick;
  logic [6:0]          r_seg_n,      w_seg_n_nxt;
  logic                r_dp_n,       w_dp_n_nxt;
  logic [N_DIGITS-1:0] r_an_n,       w_an_n_nxt;

  logic                w_div_wrap, w_frame;
  logic [3:0]          w_digit;
  logic                w_dp;
  logic                w_blank, w_zero_above;
  logic [6:0]          w_seg_dec;
  logic [N_DIGITS-1:0] w_an_sel;

  assign w_div_wrap = (r_div == DIV_W'(SCAN_DIV - 1));
  assign w_frame    = w_div_wrap && (r_idx == IDX_W'(N_DIGITS - 1));

  always_comb begin
    w_div_nxt        = w_div_wrap ? '0 : r_div + 1'b1;
    w_idx_nxt        = r_idx;
    if (w_div_wrap) w_idx_nxt = w_frame ? '0 : r_idx + 1'b1;
    w_active_dig_nxt = r_active_dig;
    w_active_dp_nxt  = r_active_dp;
    w_shadow_dig_nxt = r_shadow_dig;
    w_shadow_dp_nxt  = r_shadow_dp;
    w_pending_nxt    = r_pending;
    // Boundary transfer uses the old shadow, so a coincident load lands one frame later.
    if (w_frame && r_pending) begin
      w_active_dig_nxt = r_shadow_dig;
      w_active_dp_nxt  = r_shadow_dp;
      w_pending_nxt    = 1'b0;
    end
    if (bus.load) begin
      w_shadow_dig_nxt = bus.digits_in;
      w_shadow_dp_nxt  = bus.dp_in;
      w_pending_nxt    = 1'b1;
    end
  end

  always_comb begin
    w_digit      = '0;
    w_dp         = 1'b0;
    w_an_sel     = '1;
    w_blank      = 1'b0;
    w_zero_above = 1'b1;
    for (int i = 0; i < int'(N_DIGITS); i++) begin
      if (w_idx_nxt == IDX_W'(i)) begin
        w_digit     = w_active_dig_nxt[4*i +: 4];
        w_dp        = w_active_dp_nxt[i];
        w_an_sel[i] = 1'b0;
      end
    end
    // Walk from the top digit down; a digit is a leading zero while all above are zero.
    for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above && (w_active_dig_nxt[4*i +: 4] == 4'h0);
      if ((i != 0) && (w_idx_nxt == IDX_W'(i)) && w_zero_above) w_blank = bus.blank_lz;
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_digit),
    .o_seg_n  (w_seg_dec)
  );

  always_comb begin
    w_an_n_nxt  = '1;
    w_seg_n_nxt = SEG_BLANK;
    w_dp_n_nxt  = 1'b1;
    if (w_div_nxt != '0) begin
      w_an_n_nxt  = w_an_sel;
      w_seg_n_nxt = w_blank ? SEG_BLANK : w_seg_dec;
      w_dp_n_nxt  = ~w_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div        <= '0;
      r_idx        <= '0;
      r_shadow_dig <= '0;
      r_shadow_dp  <= '0;
      r_active_dig <= '0;
      r_active_dp  <= '0;
      r_pending    <= 1'b0;
      r_frame_tick <= 1'b0;
      r_seg_n      <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
    end else begin
      r_div        <= w_div_nxt;
      r_idx        <= w_idx_nxt;
      r_shadow_dig <= w_shadow_dig_nxt;
      r_shadow_dp  <= w_shadow_dp_nxt;
      r_active_dig <= w_active_dig_nxt;
      r_active_dp  <= w_active_dp_nxt;
      r_pending    <= w_pending_nxt;
      r_frame_tick <= w_frame;
      r_seg_n      <= w_seg_n_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_an_n       <= w_an_n_nxt;
    end
  end

  assign bus.pending    = r_pending;
  assign bus.frame_tick = r_frame_tick;
  assign bus.seg_n      = r_seg_n;
  assign bus.dp_n       = r_dp_n;
  assign bus.an_n       = r_an_n;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a time-based reference model queues the expected
// display state per clock and a monitor compares it against the DUT outputs.
module tb_seg7_scan_driver;
  localparam int ND = 4;
  localparam int SD = 4;
  localparam int FRAME = ND * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_driver_if #(.N_DIGITS(ND)) bus ();

  seg7_scan_driver #(.N_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
    logic       pend;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_err = 0;

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b0000001; seg_tab[1]  = 7'b1001111; seg_tab[2]  = 7'b0010010;
    seg_tab[3]  = 7'b0000110; seg_tab[4]  = 7'b1001100; seg_tab[5]  = 7'b0100100;
    seg_tab[6]  = 7'b0100000; seg_tab[7]  = 7'b0001111; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0000100; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b1100000;
    seg_tab[12] = 7'b0110001; seg_tab[13] = 7'b1000010; seg_tab[14] = 7'b0110000;
    seg_tab[15] = 7'b0111000;
  end

  // Model state: c counts clock edges since reset release (0 = reset state).
  int          c = 0;
  logic [15:0] m_shadow = '0, m_active = '0;
  logic [3:0]  m_sdp = '0, m_adp = '0;
  logic        m_pend = 1'b0, m_ft = 1'b0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rstn, input logic ld, input logic [15:0] d,
                            input logic [3:0] dp, input logic blz);
    exp_t e;
    int   idx;
    if (!rstn) begin
      c = 0; m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0;
      m_pend = 1'b0; m_ft = 1'b0;
    end else begin
      c++;
      m_ft = (c % FRAME == 0);
      if (m_ft && m_pend) begin
        m_active = m_shadow; m_adp = m_sdp; m_pend = 1'b0;
      end
      if (ld) begin
        m_shadow = d; m_sdp = dp; m_pend = 1'b1;
      end
    end
    idx = (c / SD) % ND;
    e.ft = m_ft;
    e.pend = m_pend;
    if (c % SD == 0) begin
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    end else begin
      e.an = ~(4'(1) << idx);
      e.dp = ~m_adp[idx];
      if (blz && idx != 0 && (m_active >> (4 * idx)) == 0) e.seg = 7'h7F;
      else e.seg = seg_tab[(m_active >> (4 * idx)) & 16'hF];
    end
    q.push_back(e);
  endtask

  task automatic cycle(input logic rstn, input logic ld, input logic [15:0] d,
                       input logic [3:0] dp, input logic blz);
    @(negedge clk);
    rst_n = rstn;
    bus.load = ld;
    bus.digits_in = d;
    bus.dp_in = dp;
    bus.blank_lz = blz;
    model_edge(rstn, ld, d, dp, blz);
  endtask

  task automatic idle(input int n, input logic blz);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 16'h0, 4'h0, blz);
  endtask

  // Idle until the next driven edge is the frame boundary (bounded by one frame).
  task automatic to_boundary(input logic blz);
    for (int i = 0; i < FRAME && ((c + 1) % FRAME != 0); i++) idle(1, blz);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an_n", 16'(bus.an_n), 16'(e.an));
        chk("seg_n", 16'(bus.seg_n), 16'(e.seg));
        chk("dp_n", 16'(bus.dp_n), 16'(e.dp));
        chk("frame_tick", 16'(bus.frame_tick), 16'(e.ft));
        chk("pending", 16'(bus.pending), 16'(e.pend));
        chk("an_onehot", 16'($countones(~bus.an_n) <= 1), 16'd1);
      end
    end
  end

  initial begin : stimulus
    bus.load = 1'b0; bus.digits_in = '0; bus.dp_in = '0; bus.blank_lz = 1'b0;
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(40, 1'b0);

    // Mid-frame load, display must hold until the boundary.
    idle(5, 1'b0);
    cycle(1'b1, 1'b1, 16'h12AF, 4'b0100, 1'b0);
    idle(40, 1'b0);

    // Leading-zero blanking.
    cycle(1'b1, 1'b1, 16'h0050, 4'b0000, 1'b1);
    idle(40, 1'b1);
    cycle(1'b1, 1'b1, 16'h0000, 4'b0010, 1'b1);
    idle(40, 1'b1);

    // Two loads in one frame: last wins.
    to_boundary(1'b0);
    idle(2, 1'b0);
    cycle(1'b1, 1'b1, 16'h1111, 4'h0, 1'b0);
    idle(3, 1'b0);
    cycle(1'b1, 1'b1, 16'h2222, 4'h0, 1'b0);
    idle(30, 1'b0);

    // Load pending, then another load exactly on the boundary edge.
    cycle(1'b1, 1'b1, 16'h3456, 4'h1, 1'b0);
    to_boundary(1'b0);
    cycle(1'b1, 1'b1, 16'h789A, 4'h8, 1'b0);
    idle(40, 1'b0);

    // Randomised traffic.
    for (int i = 0; i < 500; i++) begin
      logic [15:0] d;
      d = ($urandom_range(0, 2) == 0) ? 16'($urandom & 32'h00FF) : 16'($urandom);
      cycle(1'b1, ($urandom_range(0, 7) == 0), d, 4'($urandom), 1'($urandom));
    end

    // Asynchronous reset mid-slot with data pending.
    cycle(1'b1, 1'b1, 16'hBEEF, 4'hF, 1'b0);
    for (int i = 0; i < SD && (c % SD != 2); i++) idle(1, 1'b0);
    idle(1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.load = 1'b0;
    #1;
    chk("async_an_n", 16'(bus.an_n), 16'hF);
    chk("async_seg_n", 16'(bus.seg_n), 16'h7F);
    chk("async_dp_n", 16'(bus.dp_n), 16'h1);
    chk("async_pending", 16'(bus.pending), 16'h0);
    chk("async_frame_tick", 16'(bus.frame_tick), 16'h0);
    model_edge(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    idle(40, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    chk("queue_drained", 16'(q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
